// File: rtl/ext_uart_bridge.sv
// EXT-port UART bridge: core byte writes -> 8N1 frames on txd, 8N1 frames on rxd -> one-byte holding register.
// Optional receive path is built only when EXT_UART_RX_EN is defined; otherwise cd/crda/rx_err are tied low.
module ext_uart_bridge #(
  parameter int unsigned CLK_DIV   = 434,
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] cq,
  input  logic       cwre,
  output logic       cbsy,
  output logic [7:0] cd,
  output logic       crda,
  input  logic       cack,
  output logic       txd,
  input  logic       rxd,
  output logic       rx_err
);

  localparam logic [DIV_WIDTH-1:0] LP_BIT_LAST  = DIV_WIDTH'(CLK_DIV - 1);
  localparam logic [DIV_WIDTH-1:0] LP_HALF_LAST = DIV_WIDTH'(CLK_DIV / 2 - 1);
  localparam logic [DIV_WIDTH-1:0] LP_ONE       = DIV_WIDTH'(1);

  typedef enum logic [1:0] {TX_IDLE, TX_SHIFT, TX_STOP} tx_state_t;

  tx_state_t            r_tx_state, w_tx_state_nxt;
  logic [DIV_WIDTH-1:0] r_tx_cnt, w_tx_cnt_nxt;
  logic [3:0]           r_tx_idx, w_tx_idx_nxt;
  logic [8:0]           r_tx_sh, w_tx_sh_nxt;
  logic                 w_tx_bit_end;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_sh    <= '1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_idx   <= w_tx_idx_nxt;
      r_tx_sh    <= w_tx_sh_nxt;
    end
  end

  // Start bit sits in sh[0] below the data so SHIFT emits 9 bits straight off the LSB.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_tx_idx_nxt   = r_tx_idx;
    w_tx_sh_nxt    = r_tx_sh;
    w_tx_bit_end   = (r_tx_cnt == LP_BIT_LAST);
    case (r_tx_state)
      TX_IDLE: begin
        if (cwre) begin
          w_tx_state_nxt = TX_SHIFT;
          w_tx_sh_nxt    = {cq, 1'b0};
          w_tx_cnt_nxt   = '0;
          w_tx_idx_nxt   = '0;
        end
      end
      TX_SHIFT: begin
        if (w_tx_bit_end) begin
          w_tx_cnt_nxt = '0;
          w_tx_sh_nxt  = {1'b1, r_tx_sh[8:1]};
          if (r_tx_idx == 4'd8) w_tx_state_nxt = TX_STOP;
          else                  w_tx_idx_nxt   = r_tx_idx + 4'd1;
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + LP_ONE;
        end
      end
      TX_STOP: begin
        if (w_tx_bit_end) begin
          w_tx_cnt_nxt   = '0;
          w_tx_state_nxt = TX_IDLE;
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + LP_ONE;
        end
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
  end

  assign cbsy = (r_tx_state != TX_IDLE);
  assign txd  = (r_tx_state == TX_SHIFT) ? r_tx_sh[0] : 1'b1;

`ifdef EXT_UART_RX_EN
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t            r_rx_state, w_rx_state_nxt;
  logic                 r_rx_s1, r_rx_s2;
  logic [DIV_WIDTH-1:0] r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0]           r_rx_idx, w_rx_idx_nxt;
  logic [7:0]           r_rx_sh, w_rx_sh_nxt;
  logic                 r_rx_hold, w_rx_hold_nxt;
  logic [7:0]           r_cd, w_cd_nxt;
  logic                 r_crda, w_crda_nxt;
  logic                 r_rx_err, w_rx_err_nxt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_sh    <= '0;
      r_rx_hold  <= 1'b0;
      r_cd       <= '0;
      r_crda     <= 1'b0;
      r_rx_err   <= 1'b0;
    end else begin
      r_rx_s1    <= rxd;
      r_rx_s2    <= r_rx_s1;
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_idx   <= w_rx_idx_nxt;
      r_rx_sh    <= w_rx_sh_nxt;
      r_rx_hold  <= w_rx_hold_nxt;
      r_cd       <= w_cd_nxt;
      r_crda     <= w_crda_nxt;
      r_rx_err   <= w_rx_err_nxt;
    end
  end

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt;
    w_rx_idx_nxt   = r_rx_idx;
    w_rx_sh_nxt    = r_rx_sh;
    w_rx_hold_nxt  = r_rx_hold;
    w_cd_nxt       = r_cd;
    w_crda_nxt     = r_crda;
    w_rx_err_nxt   = 1'b0;
    if (cack && r_crda) w_crda_nxt = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        w_rx_cnt_nxt = '0;
        // After a framing error the line must go high before a new start is accepted.
        if (r_rx_hold) begin
          if (r_rx_s2) w_rx_hold_nxt = 1'b0;
        end else if (!r_rx_s2) begin
          w_rx_state_nxt = RX_START;
        end
      end
      RX_START: begin
        if (r_rx_cnt == LP_HALF_LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_idx_nxt   = '0;
          w_rx_state_nxt = r_rx_s2 ? RX_IDLE : RX_DATA;
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + LP_ONE;
        end
      end
      RX_DATA: begin
        if (r_rx_cnt == LP_BIT_LAST) begin
          w_rx_cnt_nxt = '0;
          w_rx_sh_nxt  = {r_rx_s2, r_rx_sh[7:1]};
          if (r_rx_idx == 3'd7) w_rx_state_nxt = RX_STOP;
          else                  w_rx_idx_nxt   = r_rx_idx + 3'd1;
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + LP_ONE;
        end
      end
      RX_STOP: begin
        if (r_rx_cnt == LP_BIT_LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_state_nxt = RX_IDLE;
          if (!r_rx_s2) begin
            w_rx_err_nxt  = 1'b1;
            w_rx_hold_nxt = 1'b1;
          end else if (!r_crda || cack) begin
            w_cd_nxt   = r_rx_sh;
            w_crda_nxt = 1'b1;
          end else begin
            w_rx_err_nxt = 1'b1;
          end
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + LP_ONE;
        end
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  assign cd     = r_cd;
  assign crda   = r_crda;
  assign rx_err = r_rx_err;
`else
  logic w_unused_rx;
  assign w_unused_rx = rxd ^ cack;
  assign cd          = '0;
  assign crda        = 1'b0;
  assign rx_err      = 1'b0;
`endif

endmodule

// File: tb/tb_ext_uart_bridge.sv
// Directed bench for ext_uart_bridge at CLK_DIV=4; RX scenarios run when EXT_UART_RX_EN is defined,
// otherwise the bench checks that the receive outputs stay tied low.
module tb_ext_uart_bridge;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cq;
  logic       cwre;
  logic       cbsy;
  logic [7:0] cd;
  logic       crda;
  logic       cack;
  logic       txd;
  logic       rxd;
  logic       rx_err;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ext_uart_bridge #(.CLK_DIV(4), .DIV_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .cq(cq), .cwre(cwre), .cbsy(cbsy),
    .cd(cd), .crda(crda), .cack(cack), .txd(txd), .rxd(rxd), .rx_err(rx_err)
  );

  typedef struct {
    logic [7:0] data;
    int         viol_at;
    logic [7:0] viol_data;
    bit         b2b;
  } tx_vec_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    bit         ack;
    logic       exp_crda;
    logic [7:0] exp_cd;
    logic       exp_err;
  } rx_vec_t;

  tx_vec_t tx_tab[4];
  rx_vec_t rx_tab[3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return d[k-1];
  endfunction

  task automatic send_rx(input logic [7:0] d, input logic stop);
    rxd = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (4) tick();
    end
    rxd = stop;
    repeat (4) tick();
    rxd = 1'b1;
  endtask

`ifdef EXT_UART_RX_EN
  task automatic wait_rx();
    int n = 0;
    while (!(crda || rx_err) && n < 12) begin
      tick();
      n++;
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tx_tab[0] = '{8'h42, -1, 8'h00, 1'b0};
    tx_tab[1] = '{8'h81, 13, 8'h43, 1'b1};
    tx_tab[2] = '{8'h43, -1, 8'h00, 1'b0};
    tx_tab[3] = '{8'hA5, 39, 8'h00, 1'b0};

    rx_tab[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0};
    rx_tab[1] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1};
    rx_tab[2] = '{8'h5A, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b0};

    reset = 1'b0; cq = 8'h00; cwre = 1'b0; cack = 1'b0; rxd = 1'b1;
    repeat (2) tick();
    chk("rst_txd", txd, 1);
    chk("rst_cbsy", cbsy, 0);
    chk("rst_crda", crda, 0);
    chk("rst_cd", cd, 0);
    chk("rst_rx_err", rx_err, 0);
    reset = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 4; i++) begin
      cq = tx_tab[i].data; cwre = 1'b1;
      tick();
      cwre = 1'b0; cq = 8'h00;
      for (int k = 0; k < 10; k++) begin
        for (int c = 0; c < 4; c++) begin
          chk($sformatf("tx%0d_b%0d_c%0d_txd", i, k, c), txd, frame_bit(tx_tab[i].data, k));
          chk($sformatf("tx%0d_b%0d_c%0d_cbsy", i, k, c), cbsy, 1);
          if (k * 4 + c == tx_tab[i].viol_at) begin
            cq = tx_tab[i].viol_data; cwre = 1'b1;
            tick();
            cwre = 1'b0; cq = 8'h00;
          end else begin
            tick();
          end
        end
      end
      chk($sformatf("tx%0d_end_cbsy", i), cbsy, 0);
      chk($sformatf("tx%0d_end_txd", i), txd, 1);
      if (!tx_tab[i].b2b) repeat (3) tick();
    end

`ifdef EXT_UART_RX_EN
    for (int i = 0; i < 3; i++) begin
      send_rx(rx_tab[i].data, rx_tab[i].stop);
      wait_rx();
      chk($sformatf("rx%0d_crda", i), crda, rx_tab[i].exp_crda);
      chk($sformatf("rx%0d_cd", i), cd, rx_tab[i].exp_cd);
      chk($sformatf("rx%0d_err", i), rx_err, rx_tab[i].exp_err);
      if (rx_tab[i].exp_err) begin
        tick();
        chk($sformatf("rx%0d_err_one_cycle", i), rx_err, 0);
      end
      if (rx_tab[i].ack) begin
        cack = 1'b1;
        tick();
        cack = 1'b0;
        chk($sformatf("rx%0d_ack_crda", i), crda, 0);
        chk($sformatf("rx%0d_ack_cd", i), cd, rx_tab[i].exp_cd);
      end
      repeat (3) tick();
    end

    // Overrun: second frame arrives while the first is still unconsumed.
    send_rx(8'h01, 1'b1);
    wait_rx();
    chk("ovr_first_crda", crda, 1);
    chk("ovr_first_cd", cd, 8'h01);
    send_rx(8'h02, 1'b1);
    begin
      int n = 0;
      while (!rx_err && n < 12) begin
        tick();
        n++;
      end
    end
    chk("ovr_err", rx_err, 1);
    chk("ovr_cd_kept", cd, 8'h01);
    chk("ovr_crda_kept", crda, 1);
    tick();
    chk("ovr_err_one_cycle", rx_err, 0);
    cack = 1'b1;
    tick();
    cack = 1'b0;
    chk("ovr_ack_crda", crda, 0);

    // One-cycle glitch must not produce a byte or an error.
    begin
      logic bad = 1'b0;
      rxd = 1'b0;
      tick();
      rxd = 1'b1;
      repeat (30) begin
        if (crda || rx_err) bad = 1'b1;
        tick();
      end
      chk("glitch_quiet", bad, 0);
    end
    send_rx(8'hC3, 1'b1);
    wait_rx();
    chk("post_glitch_crda", crda, 1);
    chk("post_glitch_cd", cd, 8'hC3);
`else
    begin
      logic bad = 1'b0;
      send_rx(8'hA5, 1'b1);
      repeat (12) begin
        if (crda || rx_err || cd != 8'h00) bad = 1'b1;
        tick();
      end
      chk("norx_quiet", bad, 0);
      chk("norx_crda", crda, 0);
      chk("norx_cd", cd, 0);
      chk("norx_err", rx_err, 0);
    end
`endif

    // Reset during TX bit 3 (data bit cq[2]); crda is still set from the last receive in the RX build.
    cq = 8'h00; cwre = 1'b1;
    tick();
    cwre = 1'b0;
    repeat (13) tick();
    chk("mid_pre_txd", txd, 0);
    chk("mid_pre_cbsy", cbsy, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mid_rst_txd", txd, 1);
    chk("mid_rst_cbsy", cbsy, 0);
    chk("mid_rst_crda", crda, 0);
    chk("mid_rst_cd", cd, 0);
    chk("mid_rst_err", rx_err, 0);
    repeat (8) tick();
    chk("mid_after_txd", txd, 1);
    chk("mid_after_cbsy", cbsy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
